fir_output_formatter: RTL

Downstream stage of the FIR filter core. Captures the 36-bit signed accumulator result whenever the filter pulses done. Rounds and shifts the result, saturates it to a 16-bit signed sample, and queues it in a small show-ahead FIFO. The FIFO is drained through a valid/ready handshake toward the DAC/serialiser side.

---
 rtl/fir_pkg.sv | 59 +++++
 rtl/fir_output_formatter_if.sv | 46 ++++
 rtl/fir_sample_fifo.sv | 83 ++++++++
 rtl/fir_output_formatter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR constants and the round/shift/saturate helper.
// Latency: n/a (package; round_sat is purely combinational).
// Backpressure: n/a.
//
// The accumulator and sample widths are shared with the filter core.
// round_sat is written against a 64-bit working width and takes the shift and
// output width as arguments. Any stage (formatter, future decimator) can then
// reuse it with its own widths. Callers pass elaboration-time constants, so
// the loops and shifts collapse to fixed wiring.
package fir_pkg;

    localparam int ACC_WIDTH    = 36;
    localparam int SAMPLE_WIDTH = 16;

    // Working width of round_sat. Callers sign-extend their accumulator into it.
    localparam int RS_WIDTH = 64;

    localparam logic signed [SAMPLE_WIDTH-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SAMPLE_WIDTH-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    // Steps:
    //   1. Round half toward +inf by adding 2^(shift-1).
    //   2. Arithmetic shift right by shift.
    //   3. Clamp to the signed range of outWidth bits.
    // The result is returned at RS_WIDTH+1 bits so the rounding add cannot
    // wrap. The caller truncates to outWidth, which is lossless after clamping.
    // clip reports that clamping took place.
    function automatic logic signed [RS_WIDTH:0] round_sat(
        input  logic signed [RS_WIDTH-1:0] acc,
        input  int                         shift,
        input  int                         outWidth,
        output logic                       clip
    );
        logic signed [RS_WIDTH:0] ext;
        logic signed [RS_WIDTH:0] one;
        logic signed [RS_WIDTH:0] lim;
        logic signed [RS_WIDTH:0] res;

        one  = (RS_WIDTH+1)'(1);
        ext  = {acc[RS_WIDTH-1], acc};
        if (shift > 0) begin
            ext = ext + (one <<< (shift - 1));
        end
        ext  = ext >>> shift;
        lim  = one <<< (outWidth - 1);
        clip = 1'b0;
        if (ext > (lim - one)) begin
            res  = lim - one;
            clip = 1'b1;
        end else if (ext < -lim) begin
            res  = -lim;
            clip = 1'b1;
        end else begin
            res  = ext;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_output_formatter_if.sv
// Bundle between the FIR formatter and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: sampleOut/validOut/readyIn form a valid/ready pair; the
// capture side (doneIn/dataIn) cannot be stalled.
//
// Signals:
//   doneIn/dataIn  : accumulator result strobe from the filter core
//   clearIn        : clears the sticky overflow flag
//   sampleOut      : head sample of the output FIFO
//   validOut       : head sample is valid
//   readyIn        : consumer takes the head this cycle
//   clipOut        : saturation pulse for the sample just formatted
//   overflowOut    : sticky drop flag
//   levelOut       : FIFO occupancy
// Modports:
//   slave  : formatter view
//   master : producer/consumer view
interface fir_output_formatter_if #(
    parameter int ACC_WIDTH    = fir_pkg::ACC_WIDTH,
    parameter int SAMPLE_WIDTH = fir_pkg::SAMPLE_WIDTH,
    parameter int FIFO_DEPTH   = 4
);

    localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                           doneIn;
    logic signed [ACC_WIDTH-1:0]    dataIn;
    logic                           clearIn;
    logic signed [SAMPLE_WIDTH-1:0] sampleOut;
    logic                           validOut;
    logic                           readyIn;
    logic                           clipOut;
    logic                           overflowOut;
    logic [LEVEL_WIDTH-1:0]         levelOut;

    modport slave (
        input  doneIn, dataIn, clearIn, readyIn,
        output sampleOut, validOut, clipOut, overflowOut, levelOut
    );

    modport master (
        output doneIn, dataIn, clearIn, readyIn,
        input  sampleOut, validOut, clipOut, overflowOut, levelOut
    );

endinterface

// File: rtl/fir_sample_fifo.sv
// Synchronous show-ahead FIFO for formatted samples.
// Latency: push at an edge is visible at headOut right after that edge.
// Backpressure: a push while full is ignored unless a pop happens on the same edge.
//
// Ports:
//   clkIn, nResetIn    : clock and async active-low reset
//   pushIn, pushData   : write request and data
//   popIn              : read request (ignored when empty)
//   headOut            : head entry; holds the last popped value when empty
//   emptyOut, fullOut  : status flags
//   levelOut           : occupancy, 0..DEPTH
module fir_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clkIn,
    input  logic                       nResetIn,
    input  logic                       pushIn,
    input  logic [WIDTH-1:0]           pushData,
    input  logic                       popIn,
    output logic [WIDTH-1:0]           headOut,
    output logic                       emptyOut,
    output logic                       fullOut,
    output logic [$clog2(DEPTH):0]     levelOut
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [LW-1:0]    level;
    logic [WIDTH-1:0] lastQ;
    logic             doPush;
    logic             doPop;

    assign emptyOut = (level == '0);
    assign fullOut  = (level == LW'(DEPTH));
    assign levelOut = level;

    // A pop frees the slot on the same edge, so a push to a full FIFO with a
    // simultaneous pop is still accepted.
    assign doPop  = popIn && !emptyOut;
    assign doPush = pushIn && (!fullOut || doPop);

    // The pointers are exactly AW bits wide, so they wrap modulo DEPTH
    // (DEPTH is a power of two).
    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
            lastQ <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
                lastQ <= mem[rdPtr];
            end
            case ({doPush, doPop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // The storage array is not reset. Entries are only observed through the
    // level-qualified head mux below.
    always_ff @(posedge clkIn) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // When empty, the head shows the last sample that left the FIFO
    // (zero after reset) rather than a stale slot.
    assign headOut = emptyOut ? lastQ : mem[rdPtr];

endmodule

// File: rtl/fir_output_formatter.sv
// Capture FIR accumulator results, round/shift/saturate them to samples, and queue them.
// Latency: doneIn sampled at edge E0 -> sample in FIFO (validOut) after edge E0+2.
// Backpressure: capture never stalls; when the FIFO is full and not popping,
// the sample is dropped and overflowOut latches.
//
// Ports:
//   clkIn     : system clock
//   nResetIn  : async active-low reset; clears pipeline, FIFO and flags
//   fmtBus    : fir_output_formatter_if.slave
//               (doneIn/dataIn/clearIn in, sample stream + status out)
module fir_output_formatter #(
    parameter int ACC_WIDTH    = fir_pkg::ACC_WIDTH,
    parameter int SAMPLE_WIDTH = fir_pkg::SAMPLE_WIDTH,
    parameter int SHIFT        = 15,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clkIn,
    input  logic                    nResetIn,
    fir_output_formatter_if.slave   fmtBus
);

    import fir_pkg::*;

    localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

    // Stage 1: capture
    logic signed [ACC_WIDTH-1:0]    accQ;
    logic                           v1Q;

    // Stage 2: format
    logic signed [SAMPLE_WIDTH-1:0] fmtD;
    logic                           clipD;
    logic signed [SAMPLE_WIDTH-1:0] fmtQ;
    logic                           clipQ;
    logic                           v2Q;

    // Stage 3: push and status
    logic                           clipOutQ;
    logic                           overflowQ;
    logic                           popReq;
    logic                           dropNow;
    logic [SAMPLE_WIDTH-1:0]        fifoHead;
    logic                           fifoEmpty;
    logic                           fifoFull;
    logic [LEVEL_WIDTH-1:0]         fifoLevel;

    // dataIn is only looked at on a doneIn strobe.
    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            accQ <= '0;
            v1Q  <= 1'b0;
        end else begin
            v1Q <= fmtBus.doneIn;
            if (fmtBus.doneIn) begin
                accQ <= fmtBus.dataIn;
            end
        end
    end

    // The accumulator is sign-extended into the helper's working width. The
    // clamped result always fits SAMPLE_WIDTH bits, so the truncating cast
    // loses nothing.
    always_comb begin
        clipD = 1'b0;
        fmtD  = SAMPLE_WIDTH'(round_sat(RS_WIDTH'(accQ), SHIFT, SAMPLE_WIDTH, clipD));
    end

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            fmtQ  <= '0;
            clipQ <= 1'b0;
            v2Q   <= 1'b0;
        end else begin
            v2Q <= v1Q;
            if (v1Q) begin
                fmtQ  <= fmtD;
                clipQ <= clipD;
            end
        end
    end

    // A pop is gated by the registered empty flag only. readyIn therefore
    // never reaches validOut combinationally.
    assign popReq  = !fifoEmpty && fmtBus.readyIn;
    assign dropNow = v2Q && fifoFull && !popReq;

    fir_sample_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clkIn    (clkIn),
        .nResetIn (nResetIn),
        .pushIn   (v2Q),
        .pushData (fmtQ),
        .popIn    (popReq),
        .headOut  (fifoHead),
        .emptyOut (fifoEmpty),
        .fullOut  (fifoFull),
        .levelOut (fifoLevel)
    );

    // clipOut reports the saturation result of every sample leaving the
    // format stage. A dropped sample is reported separately through
    // overflowOut. For overflow, a drop in the same cycle as clearIn
    // leaves the flag set.
    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            clipOutQ  <= 1'b0;
            overflowQ <= 1'b0;
        end else begin
            clipOutQ <= v2Q && clipQ;
            if (dropNow) begin
                overflowQ <= 1'b1;
            end else if (fmtBus.clearIn) begin
                overflowQ <= 1'b0;
            end
        end
    end

    assign fmtBus.sampleOut   = fifoHead;
    assign fmtBus.validOut    = !fifoEmpty;
    assign fmtBus.clipOut     = clipOutQ;
    assign fmtBus.overflowOut = overflowQ;
    assign fmtBus.levelOut    = fifoLevel;

endmodule
